// File: rtl/mem_line_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_line_responder_pkg
// Shared definitions for the line-granular memory responder: FSM state
// encoding and cache-line geometry (16-byte lines, 4 words per line,
// 20-bit tag + 8-bit index forming the 28-bit line address).
// Ports: none (package).
// -----------------------------------------------------------------------------
package mem_line_responder_pkg;

  localparam int LINE_WORDS  = 4;
  localparam int OFFSET_BITS = 4;
  localparam int INDEX_BITS  = 8;
  localparam int TAG_BITS    = 20;

  // Line address = byte address with the in-line offset stripped.
  localparam int LINE_ADDR_W = TAG_BITS + INDEX_BITS;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD_BURST,
    WR_BURST,
    DONE
  } state_t;

endpackage

// File: rtl/mem_line_responder_if.sv
// -----------------------------------------------------------------------------
// mem_line_responder_if
// Bundles the line request, write-back beat and refill beat handshakes.
//   req_valid/req_ready/req_write/req_addr : line request
//   wr_valid/wr_data/wr_ready              : write-back beats (requester -> responder)
//   rd_valid/rd_data/rd_last               : refill beats (responder -> requester)
//   resp_done                              : one-cycle completion pulse
//   resp_err                               : present only with MEM_RESP_ERR_EN
// Modports: master (requester side), slave (responder side).
// -----------------------------------------------------------------------------
interface mem_line_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        resp_done;
`ifdef MEM_RESP_ERR_EN
  logic        resp_err;
`endif

  modport master (
    output req_valid, req_write, req_addr, wr_valid, wr_data,
    input  req_ready, wr_ready, rd_valid, rd_data, rd_last, resp_done
`ifdef MEM_RESP_ERR_EN
    , input resp_err
`endif
  );

  modport slave (
    input  req_valid, req_write, req_addr, wr_valid, wr_data,
    output req_ready, wr_ready, rd_valid, rd_data, rd_last, resp_done
`ifdef MEM_RESP_ERR_EN
    , output resp_err
`endif
  );

endinterface

// File: rtl/mem_line_store.sv
// -----------------------------------------------------------------------------
// mem_line_store
// Single-port word-addressed backing store: combinational read, synchronous
// write. Contents are never cleared, so reset leaves stored data intact.
// Ports:
//   clk   : clock
//   we    : write enable (word addr/wdata written on posedge)
//   addr  : word index, log2(MEM_WORDS) bits
//   wdata : write data
//   rdata : word at addr, combinational
// -----------------------------------------------------------------------------
module mem_line_store #(
  parameter int MEM_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_WORDS)-1:0] addr,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_line_responder.sv
// -----------------------------------------------------------------------------
// mem_line_responder
// Serves 16-byte line refills and write-backs from a local word store.
// A request is accepted in IDLE, waits LATENCY cycles, then streams four
// refill beats (no backpressure) or accepts four write-back beats (gaps on
// wr_valid stall the beat counter), then pulses resp_done for one cycle.
// Ports:
//   clk : clock, all logic on posedge
//   rst : synchronous active-high reset (FSM/counters only, not the store)
//   bus : mem_line_responder_if.slave (request, write beats, read beats,
//         completion; resp_err when MEM_RESP_ERR_EN is defined)
// Parameters:
//   LATENCY   : idle cycles between accept and first beat/write-ready (1..15)
//   MEM_WORDS : store depth in 32-bit words (power of two, multiple of 4)
// Build option:
//   MEM_RESP_ERR_EN : out-of-range line addresses flag resp_err, suppress
//                     writes and return zero data; otherwise addresses wrap.
// -----------------------------------------------------------------------------
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_line_responder_if.slave  bus
);

  localparam int WORD_AW = $clog2(MEM_WORDS);
  localparam int BEAT_W  = $clog2(LINE_WORDS);
  localparam int CNT_W   = 4;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    wait_cnt, wait_cnt_nxt;
  logic [BEAT_W-1:0]   beat, beat_nxt;

  logic                accept;
  logic                store_we;
  logic                req_ready, wr_ready, rd_valid, rd_last, resp_done;

  logic [LINE_ADDR_W-1:0] req_line_p0;
  logic                   req_write_p0;
  logic                   req_err_p0;

  logic [WORD_AW-1:0]  word_addr;
  logic [31:0]         store_rdata;

  // Byte offset within the line is not used for addressing.
  logic unused_offset_bits;
  assign unused_offset_bits = ^bus.req_addr[OFFSET_BITS-1:0];

  // ---- request capture stage: line address/direction held for the transaction
  always_ff @(posedge clk) begin
    if (accept) begin
      req_line_p0  <= bus.req_addr[31:OFFSET_BITS];
      req_write_p0 <= bus.req_write;
    end
  end

`ifdef MEM_RESP_ERR_EN
  // Line addresses past the end of the store are flagged instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_err_p0 <= 1'b0;
    end else if (accept) begin
      req_err_p0 <= (bus.req_addr[31:OFFSET_BITS] >
                     LINE_ADDR_W'(MEM_WORDS / LINE_WORDS - 1));
    end
  end

  assign bus.resp_err = resp_done & req_err_p0;
`else
  assign req_err_p0 = 1'b0;
`endif

  // ---- FSM state and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      beat     <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      beat     <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    beat_nxt     = beat;
    accept       = 1'b0;
    store_we     = 1'b0;
    req_ready    = 1'b0;
    wr_ready     = 1'b0;
    rd_valid     = 1'b0;
    rd_last      = 1'b0;
    resp_done    = 1'b0;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          accept       = 1'b1;
          // Counting LATENCY-1 down to 0 gives exactly LATENCY WAIT cycles.
          wait_cnt_nxt = CNT_W'(LATENCY - 1);
          beat_nxt     = '0;
          state_nxt    = WAIT;
        end
      end

      WAIT: begin
        if (wait_cnt == '0) begin
          state_nxt = req_write_p0 ? WR_BURST : RD_BURST;
        end else begin
          wait_cnt_nxt = wait_cnt - 1'b1;
        end
      end

      RD_BURST: begin
        rd_valid = 1'b1;
        rd_last  = (beat == BEAT_W'(LINE_WORDS - 1));
        beat_nxt = beat + 1'b1;
        if (rd_last) begin
          state_nxt = DONE;
        end
      end

      WR_BURST: begin
        wr_ready = 1'b1;
        if (bus.wr_valid) begin
          store_we = !req_err_p0;
          beat_nxt = beat + 1'b1;
          if (beat == BEAT_W'(LINE_WORDS - 1)) begin
            state_nxt = DONE;
          end
        end
      end

      DONE: begin
        resp_done = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---- store access: word index wraps modulo MEM_WORDS by truncation
  assign word_addr = WORD_AW'({req_line_p0, beat});

  mem_line_store #(
    .MEM_WORDS(MEM_WORDS)
  ) u_store (
    .clk   (clk),
    .we    (store_we & ~rst),
    .addr  (word_addr),
    .wdata (bus.wr_data),
    .rdata (store_rdata)
  );

  assign bus.req_ready = req_ready;
  assign bus.wr_ready  = wr_ready;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_last   = rd_last;
  assign bus.resp_done = resp_done;
  assign bus.rd_data   = (rd_valid && !req_err_p0) ? store_rdata : 32'd0;

endmodule

// File: doc/mem_line_responder.md
MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

Interface
REQ-001 SHALL have parameter LATENCY, 4, idle cycles between request accept and first beat or write-ready (range 1..15).
REQ-002 SHALL have parameter MEM_WORDS, 1024, backing-store depth in 32-bit words (power of two, multiple of 4).
REQ-003 SHALL have ports: clk  input  1  single clock, all logic on posedge.
REQ-004 SHALL have ports: rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports: req_valid  input  1  line request present.
REQ-006 SHALL have ports: req_ready  output  1  responder can accept a request.
REQ-007 SHALL have ports: req_write  input  1  1 = write-back line, 0 = refill (read) line.
REQ-008 SHALL have ports: req_addr  input  32  byte address; bits [3:0] ignored (16-byte line, 20-bit tag, 8-bit index).
REQ-009 SHALL have ports: wr_valid  input  1, wr_data  input  32, wr_ready  output  1  write-back beat handshake.
REQ-010 SHALL have ports: rd_valid  output  1, rd_data  output  32, rd_last  output  1  refill beats (no backpressure).
REQ-011 SHALL have ports: resp_done  output  1  one-cycle pulse when a line transaction completes.

Function
REQ-012 SHALL implement states IDLE, WAIT, RD_BURST, WR_BURST, DONE.
REQ-013 req_ready SHALL be 1 only in IDLE; request accepted on req_valid && req_ready; req_write and line address (req_addr[31:4]) registered then.
REQ-014 WAIT SHALL last exactly LATENCY cycles via a down-counter, then go to RD_BURST (read) or WR_BURST (write).
REQ-015 RD_BURST SHALL drive rd_valid=1 for exactly 4 consecutive cycles, beats at word offsets 0,1,2,3; rd_last=1 on beat 3 only.
REQ-016 rd_data SHALL be the stored word for the current beat, valid in the same cycle as rd_valid.
REQ-017 WR_BURST SHALL hold wr_ready=1; each cycle with wr_valid=1 writes wr_data to the next word offset; wr_valid gaps SHALL stall the beat counter without loss.
REQ-018 After beat 3 (read or write) the FSM SHALL enter DONE, assert resp_done for one cycle, and return to IDLE; next accept is earliest the following cycle.
REQ-019 Word index SHALL be {line address, beat[1:0]} truncated to log2(MEM_WORDS) bits (wrap modulo MEM_WORDS) unless REQ-024 applies.
REQ-020 A read to a line written by an earlier completed write-back SHALL return the written data.
REQ-021 wr_valid outside WR_BURST and req_valid outside IDLE SHALL be ignored.

Reset
REQ-022 On rst: state IDLE, counters 0, req_ready=1 the cycle after reset releases, rd_valid=0, rd_last=0, wr_ready=0, resp_done=0, rd_data=0.
REQ-023 Reset mid-transaction SHALL abort it with no further beats or resp_done; words already written SHALL remain; store contents are not cleared by reset.

Configuration
REQ-024 Macro MEM_RESP_ERR_EN defined: add output resp_err (1 bit); a request whose line address exceeds MEM_WORDS/4-1 SHALL complete normal handshake timing, suppress all store writes, return rd_data=0, and assert resp_err together with resp_done; resp_err resets to 0.
REQ-025 Macro MEM_RESP_ERR_EN undefined: no resp_err port; addresses wrap per REQ-019.

Structure
REQ-026 Shared package SHALL hold the FSM state enum, LINE_WORDS=4, OFFSET_BITS=4, INDEX_BITS=8, TAG_BITS=20.
REQ-027 Backing store SHALL be a sub-module mem_line_store (single-port, combinational read, synchronous write); FSM and counters stay in mem_line_responder.

Verification
REQ-028 Reset, then read line 0x00000010 with LATENCY=4 -> req accept at cycle t, rd_valid at t+5..t+8, rd_last at t+8, resp_done at t+9.
REQ-029 Write-back to 0x00000040 data A0,A1,A2,A3 with wr_valid gap after beat 1, then read 0x00000040 -> rd_data A0,A1,A2,A3, rd_last on A3.
REQ-030 Back-to-back requests held on req_valid -> second accepted exactly one cycle after first resp_done, req_ready low throughout first transaction.
REQ-031 Assert rst during RD_BURST beat 1 -> rd_valid 0 next cycle, no resp_done, req_ready 1 after release.
REQ-032 With MEM_RESP_ERR_EN, read 0x00010000 with MEM_WORDS=1024 -> four beats of 0, resp_err=1 with resp_done; without macro, same read returns line 0x00000000 data.
